msoc_mem_copy_master: RTL and testbench
=======================================

Name: msoc_mem_copy_master

Overview:
- Avalon-MM master that copies a block of 32-bit words from a source region to a destination region over the system interconnect.
- Typical targets are the on-chip RAM slaves, e.g. a 16384-word, 32-bit single-port memory.
- Started by a one-cycle command pulse. Issues one read, then one write, per word, with one transaction outstanding at a time.
- Sits beside the CPU as a simple block-move/DMA engine.

Parameters:
- ADDR_W, 16, byte-address width of avm_address (64 KiB window; word addresses are ADDR_W-2 bits).
- LEN_W, 15, width of the word-count input (maximum 2^LEN_W-1 words).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset; deassertion is synchronous to clk externally.
- start  in  1  one-cycle command pulse; sampled only in IDLE.
- src_addr  in  ADDR_W  source byte address; bits [1:0] ignored (treated as 0).
- dst_addr  in  ADDR_W  destination byte address; bits [1:0] ignored.
- length  in  LEN_W  number of 32-bit words to copy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the copy completes.
- avm_address  out  ADDR_W  byte address; bits [1:0] always 0.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_byteenable  out  4  always 4'b1111 while read or write is high; 0 otherwise.
- avm_writedata  out  32  data being written.
- avm_waitrequest  in  1  slave stall; the request is accepted when it is low.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  qualifies avm_readdata.

Behaviour:
- Reset values (async, reset_n=0): state=IDLE; busy=0, done=0, avm_read=0, avm_write=0, avm_byteenable=0, avm_address=0, avm_writedata=0; internal src/dst/count registers=0.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, FIN.
- IDLE:
  - On start=1 with length!=0: latch src_addr&~3, dst_addr&~3 and length into src_ptr, dst_ptr, remaining → RD_REQ; busy=1 next cycle.
  - On start=1 with length==0: → FIN with no bus traffic, so done pulses 2 cycles after start.
  - start=0: stay.
- RD_REQ:
  - avm_read=1, avm_address=src_ptr.
  - Hold all outputs stable while avm_waitrequest=1.
  - Acceptance (avm_read & ~avm_waitrequest) → RD_WAIT and deassert avm_read the next cycle.
- RD_WAIT:
  - No request is driven.
  - On avm_readdatavalid=1: capture avm_readdata into avm_writedata → WR_REQ.
  - readdatavalid is never expected in RD_REQ; if it arrives in any state other than RD_WAIT it is ignored.
- WR_REQ:
  - avm_write=1, avm_address=dst_ptr; outputs held while waitrequest=1.
  - On acceptance: src_ptr+=4, dst_ptr+=4, remaining-=1.
  - If remaining was 1 → FIN, else → RD_REQ.
- FIN:
  - done=1 for exactly this cycle, busy=0 on the same edge → IDLE.
- Throughput: zero-wait-state slave with read latency 1 gives 3 cycles per word. Block of N words: done asserts 3N+1 cycles after the start cycle.
- Pointer arithmetic is modulo 2^ADDR_W; a pointer at 0xFFFC wraps to 0x0000 with no error.
- Overlapping regions are copied in ascending address order; no overlap detection.
- start while busy: ignored; no queueing.
- avm_read and avm_write are never high in the same cycle.
- Asynchronous reset mid-transfer aborts immediately: request lines drop combinationally with reset, and done is not pulsed.

Optional Feature:
- Macro MSOC_COPY_CHECKSUM_EN.
- When defined:
  - Adds output checksum [31:0], reset value 0.
  - Cleared to 0 when a start is accepted in IDLE.
  - On each write acceptance, checksum <= checksum + avm_writedata (mod 2^32).
  - Value is stable and final when done pulses; held until the next accepted start.
- When undefined: the port and adder are absent; all other behaviour is identical.

Test Plan:
- Basic copy: preload src 0x0100..0x010C = 0x11111111, 0x22222222, 0x33333333, 0x44444444; start with src=0x0100, dst=0x2000, length=4, zero waitrequest, latency 1 → dst words match, done exactly 13 cycles after the start cycle, busy low after; checksum=0xAAAAAAAA if enabled.
- Zero length: start with length=0 → no avm_read/avm_write ever high; done pulses 2 cycles after start.
- Backpressure: waitrequest high for 3 cycles on each request → address/read/write/writedata held constant throughout; final memory contents identical to the basic copy.
- Wrap-around and alignment: src=0xFFFE (treated as 0xFFFC), length=2 → reads at 0xFFFC then 0x0000.
- Start while busy: second start pulse mid-copy with different addresses → ignored; exactly length writes occur, to the first dst only.
- Reset mid-operation: reset_n low during WR_REQ of word 2 → avm_write drops immediately, done never pulses, all outputs at reset values; a new start after release runs normally.

Source files
------------

// File: rtl/msoc_mem_copy_master_if.sv
// Avalon-MM bus bundle between the block-copy master and the interconnect.
interface msoc_mem_copy_master_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_writedata;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;

  modport master (
    output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/msoc_mem_copy_master.sv
// Word-by-word block copy master: one read then one write per word, single outstanding access.
// Optional running checksum of written words is enabled by defining MSOC_COPY_CHECKSUM_EN.
module msoc_mem_copy_master #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
`ifdef MSOC_COPY_CHECKSUM_EN
  output logic [31:0]       checksum,
`endif
  msoc_mem_copy_master_if.master avm
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, FIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] srcPtr_q, dstPtr_q;
  logic [LEN_W-1:0]  remaining_q;
  logic [31:0]       wdata_q;
  logic              zeroLen_q;
  logic              rdAccept, wrAccept;

  assign rdAccept = (state_q == RD_REQ) && !avm.avm_waitrequest;
  assign wrAccept = (state_q == WR_REQ) && !avm.avm_waitrequest;

  // A zero-length command parks in FIN for one extra (busy, not done) cycle
  // so its done pulse lands two cycles after the start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      srcPtr_q    <= '0;
      dstPtr_q    <= '0;
      remaining_q <= '0;
      wdata_q     <= '0;
      zeroLen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            zeroLen_q <= (length == '0);
            if (length != '0) begin
              srcPtr_q    <= {src_addr[ADDR_W-1:2], 2'b00};
              dstPtr_q    <= {dst_addr[ADDR_W-1:2], 2'b00};
              remaining_q <= length;
            end
          end
        end
        RD_WAIT: begin
          if (avm.avm_readdatavalid) wdata_q <= avm.avm_readdata;
        end
        WR_REQ: begin
          if (wrAccept) begin
            srcPtr_q    <= srcPtr_q + ADDR_W'(4);
            dstPtr_q    <= dstPtr_q + ADDR_W'(4);
            remaining_q <= remaining_q - LEN_W'(1);
          end
        end
        FIN: zeroLen_q <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (length != '0) ? RD_REQ : FIN;
      RD_REQ:  if (rdAccept) state_d = RD_WAIT;
      RD_WAIT: if (avm.avm_readdatavalid) state_d = WR_REQ;
      WR_REQ:  if (wrAccept) state_d = (remaining_q == LEN_W'(1)) ? FIN : RD_REQ;
      FIN:     if (!zeroLen_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request lines decode straight from the state so an async reset drops them at once.
  always_comb begin
    avm.avm_read       = 1'b0;
    avm.avm_write      = 1'b0;
    avm.avm_address    = '0;
    avm.avm_byteenable = 4'b0000;
    avm.avm_writedata  = wdata_q;
    busy               = 1'b0;
    done               = 1'b0;
    case (state_q)
      RD_REQ: begin
        avm.avm_read       = 1'b1;
        avm.avm_address    = srcPtr_q;
        avm.avm_byteenable = 4'b1111;
        busy               = 1'b1;
      end
      RD_WAIT: busy = 1'b1;
      WR_REQ: begin
        avm.avm_write      = 1'b1;
        avm.avm_address    = dstPtr_q;
        avm.avm_byteenable = 4'b1111;
        busy               = 1'b1;
      end
      FIN: begin
        busy = zeroLen_q;
        done = !zeroLen_q;
      end
      default: ;
    endcase
  end

`ifdef MSOC_COPY_CHECKSUM_EN
  logic [31:0] checksum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum_q <= '0;
    end else if (state_q == IDLE && start) begin
      checksum_q <= '0;
    end else if (wrAccept) begin
      checksum_q <= checksum_q + wdata_q;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_msoc_mem_copy_master.sv
// Directed bench for msoc_mem_copy_master against a behavioural Avalon-MM RAM slave.
// Checksum comparisons are compiled in when MSOC_COPY_CHECKSUM_EN is defined.
module tb_msoc_mem_copy_master;
  localparam int ADDR_W = 16;
  localparam int LEN_W  = 15;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] src_addr = '0;
  logic [ADDR_W-1:0] dst_addr = '0;
  logic [LEN_W-1:0]  length = '0;
  logic              busy, done;
`ifdef MSOC_COPY_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  int compared = 0;
  int mismatched = 0;

  msoc_mem_copy_master_if #(.ADDR_W(ADDR_W)) bus ();

  msoc_mem_copy_master #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
`ifdef MSOC_COPY_CHECKSUM_EN
    .checksum (checksum),
`endif
    .avm      (bus.master)
  );

  always #5 clk = ~clk;

  // Slave model: stallCfg wait cycles per request, read latency 1, plus bus monitors.
  logic [31:0]       mem [0:16383];
  logic [ADDR_W-1:0] readLog [0:255];
  logic [ADDR_W-1:0] writeLog [0:255];
  int cyc = 0, stallCfg = 0, stallCnt = 0;
  int readCount = 0, writeCount = 0, doneCount = 0;
  int bothErr = 0, holdErr = 0, stallSeen = 0;
  logic              prevStalled = 1'b0;
  logic [ADDR_W-1:0] prevAddr = '0;
  logic              prevRead = 1'b0, prevWrite = 1'b0;
  logic [31:0]       prevWdata = '0;

  assign bus.avm_waitrequest = (bus.avm_read || bus.avm_write) && (stallCnt != 0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.avm_readdatavalid <= 1'b0;
    if (bus.avm_read || bus.avm_write)
      stallCnt <= (stallCnt != 0) ? stallCnt - 1 : stallCfg;
    else
      stallCnt <= stallCfg;
    if (bus.avm_read && !bus.avm_waitrequest) begin
      bus.avm_readdatavalid <= 1'b1;
      bus.avm_readdata      <= mem[bus.avm_address[15:2]];
      if (readCount < 256) readLog[readCount] <= bus.avm_address;
      readCount <= readCount + 1;
    end
    if (bus.avm_write && !bus.avm_waitrequest) begin
      mem[bus.avm_address[15:2]] <= bus.avm_writedata;
      if (writeCount < 256) writeLog[writeCount] <= bus.avm_address;
      writeCount <= writeCount + 1;
    end
    if (bus.avm_read && bus.avm_write) bothErr <= bothErr + 1;
    if (done) doneCount <= doneCount + 1;
    if (bus.avm_waitrequest) stallSeen <= stallSeen + 1;
    if (reset_n && prevStalled &&
        (bus.avm_address !== prevAddr || bus.avm_read !== prevRead ||
         bus.avm_write !== prevWrite || bus.avm_writedata !== prevWdata))
      holdErr <= holdErr + 1;
    prevStalled <= (bus.avm_read || bus.avm_write) && bus.avm_waitrequest;
    prevAddr    <= bus.avm_address;
    prevRead    <= bus.avm_read;
    prevWrite   <= bus.avm_write;
    prevWdata   <= bus.avm_writedata;
  end

  int startCyc = 0;

  task automatic applyStimulus(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                               input logic [LEN_W-1:0] n);
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    length   = n;
    start    = 1'b1;
    startCyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output int latency, output bit timedOut);
    timedOut = 1'b1;
    latency  = -1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        latency  = cyc - startCyc;
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  task automatic preloadBasic(input logic [ADDR_W-1:0] d);
    mem[16'h0100 >> 2] = 32'h11111111;
    mem[16'h0104 >> 2] = 32'h22222222;
    mem[16'h0108 >> 2] = 32'h33333333;
    mem[16'h010C >> 2] = 32'h44444444;
    for (int i = 0; i < 4; i++) mem[(d >> 2) + i] = 32'h0;
  endtask

  task automatic checkBasicDst(input string tag, input logic [ADDR_W-1:0] d);
    logic [31:0] exp;
    for (int i = 0; i < 4; i++) begin
      exp = {4{4'(i + 1), 4'(i + 1)}};
      compared++;
      if (mem[(d >> 2) + i] !== exp) begin
        mismatched++;
        $display("[TB] FAIL %s word%0d: got %h expected %h", tag, i, mem[(d >> 2) + i], exp);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({busy, done, bus.avm_read, bus.avm_write} !== 4'b0000 || bus.avm_byteenable !== 4'h0 ||
        bus.avm_address !== 16'h0 || bus.avm_writedata !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: busy=%b done=%b rd=%b wr=%b be=%h addr=%h wd=%h, all zero expected",
               busy, done, bus.avm_read, bus.avm_write, bus.avm_byteenable, bus.avm_address, bus.avm_writedata);
    end
`ifdef MSOC_COPY_CHECKSUM_EN
    compared++;
    if (checksum !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_checksum: got %h expected 0", checksum);
    end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_copy();
    int lat; bit to; int wBase, bBase;
    stallCfg = 0;
    preloadBasic(16'h2000);
    wBase = writeCount;
    bBase = bothErr;
    applyStimulus(16'h0100, 16'h2000, 15'd4);
    waitDone(lat, to);
    compared++;
    if (to || lat != 13) begin
      mismatched++;
      $display("[TB] FAIL basic_latency: got %0d (timeout=%0d) expected 13", lat, to);
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL basic_busy_at_done: got %b expected 0", busy);
    end
    @(negedge clk);
    checkBasicDst("basic_dst", 16'h2000);
    compared++;
    if (writeCount - wBase != 4 || bothErr != bBase) begin
      mismatched++;
      $display("[TB] FAIL basic_writes: got %0d writes, %0d rd+wr overlaps; expected 4, 0",
               writeCount - wBase, bothErr - bBase);
    end
`ifdef MSOC_COPY_CHECKSUM_EN
    compared++;
    if (checksum !== 32'hAAAAAAAA) begin
      mismatched++;
      $display("[TB] FAIL basic_checksum: got %h expected aaaaaaaa", checksum);
    end
`endif
  endtask

  task automatic test_zero_length();
    int lat; bit to; int base;
    base = readCount + writeCount;
    applyStimulus(16'h0100, 16'h2500, 15'd0);
    waitDone(lat, to);
    compared++;
    if (to || lat != 2) begin
      mismatched++;
      $display("[TB] FAIL zero_latency: got %0d (timeout=%0d) expected 2", lat, to);
    end
    @(negedge clk);
    compared++;
    if (readCount + writeCount != base) begin
      mismatched++;
      $display("[TB] FAIL zero_traffic: got %0d accesses expected 0", readCount + writeCount - base);
    end
`ifdef MSOC_COPY_CHECKSUM_EN
    compared++;
    if (checksum !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL zero_checksum: got %h expected 0", checksum);
    end
`endif
  endtask

  task automatic test_backpressure();
    int lat; bit to; int hBase, sBase;
    preloadBasic(16'h2000);
    hBase = holdErr;
    sBase = stallSeen;
    stallCfg = 3;
    applyStimulus(16'h0100, 16'h2000, 15'd4);
    waitDone(lat, to);
    compared++;
    if (to || lat != 37) begin
      mismatched++;
      $display("[TB] FAIL bp_latency: got %0d (timeout=%0d) expected 37", lat, to);
    end
    @(negedge clk);
    stallCfg = 0;
    compared++;
    if (holdErr != hBase || stallSeen - sBase != 24) begin
      mismatched++;
      $display("[TB] FAIL bp_hold: got %0d unstable cycles, %0d stalls; expected 0, 24",
               holdErr - hBase, stallSeen - sBase);
    end
    checkBasicDst("bp_dst", 16'h2000);
  endtask

  task automatic test_wrap();
    int lat; bit to; int rBase;
    mem[16'h3FFF] = 32'hCAFEF00D;
    mem[16'h0000] = 32'h0BADBEEF;
    mem[16'h3000 >> 2] = 32'h0;
    mem[(16'h3000 >> 2) + 1] = 32'h0;
    rBase = readCount;
    applyStimulus(16'hFFFE, 16'h3003, 15'd2);
    waitDone(lat, to);
    @(negedge clk);
    compared++;
    if (to || readCount - rBase != 2 || readLog[rBase] !== 16'hFFFC || readLog[rBase + 1] !== 16'h0000) begin
      mismatched++;
      $display("[TB] FAIL wrap_reads: got %0d reads at %h,%h expected 2 at fffc,0000",
               readCount - rBase, readLog[rBase], readLog[rBase + 1]);
    end
    compared++;
    if (mem[16'h3000 >> 2] !== 32'hCAFEF00D || mem[(16'h3000 >> 2) + 1] !== 32'h0BADBEEF) begin
      mismatched++;
      $display("[TB] FAIL wrap_dst: got %h,%h expected cafef00d,0badbeef",
               mem[16'h3000 >> 2], mem[(16'h3000 >> 2) + 1]);
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit to; int wBase; bit badAddr;
    preloadBasic(16'h4000);
    mem[16'h5000 >> 2] = 32'hDEADDEAD;
    mem[(16'h5000 >> 2) + 1] = 32'hDEADDEAD;
    wBase = writeCount;
    applyStimulus(16'h0100, 16'h4000, 15'd4);
    repeat (3) @(negedge clk);
    src_addr = 16'h0200;
    dst_addr = 16'h5000;
    length   = 15'd2;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(lat, to);
    compared++;
    if (to || lat != 13) begin
      mismatched++;
      $display("[TB] FAIL busy_start_latency: got %0d (timeout=%0d) expected 13", lat, to);
    end
    repeat (10) @(negedge clk);
    badAddr = 1'b0;
    for (int i = 0; i < 4; i++)
      if (writeLog[wBase + i] !== 16'h4000 + 16'(4 * i)) badAddr = 1'b1;
    compared++;
    if (writeCount - wBase != 4 || badAddr) begin
      mismatched++;
      $display("[TB] FAIL busy_start_writes: got %0d writes (addr error=%0d) expected 4 to 4000..400c",
               writeCount - wBase, badAddr);
    end
    compared++;
    if (mem[16'h5000 >> 2] !== 32'hDEADDEAD || mem[(16'h5000 >> 2) + 1] !== 32'hDEADDEAD) begin
      mismatched++;
      $display("[TB] FAIL busy_start_untouched: got %h,%h expected deaddead", mem[16'h5000 >> 2],
               mem[(16'h5000 >> 2) + 1]);
    end
    checkBasicDst("busy_start_dst", 16'h4000);
  endtask

  task automatic test_reset_mid_op();
    int lat; bit to; int wBase, dBase; bit found;
    preloadBasic(16'h6000);
    wBase = writeCount;
    applyStimulus(16'h0100, 16'h6000, 15'd4);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (writeCount - wBase == 1 && bus.avm_write) begin
        found = 1'b1;
        break;
      end
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("[TB] FAIL midreset_reach_word2: got no second write request, expected one");
    end
    dBase = doneCount;
    reset_n = 1'b0;
    #1;
    compared++;
    if ({busy, done, bus.avm_read, bus.avm_write} !== 4'b0000 || bus.avm_byteenable !== 4'h0 ||
        bus.avm_address !== 16'h0 || bus.avm_writedata !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL midreset_outputs: busy=%b done=%b rd=%b wr=%b be=%h addr=%h wd=%h, all zero expected",
               busy, done, bus.avm_read, bus.avm_write, bus.avm_byteenable, bus.avm_address, bus.avm_writedata);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    compared++;
    if (doneCount != dBase || writeCount - wBase != 1) begin
      mismatched++;
      $display("[TB] FAIL midreset_abort: got %0d done pulses, %0d writes; expected 0, 1",
               doneCount - dBase, writeCount - wBase);
    end
    applyStimulus(16'h0100, 16'h6000, 15'd4);
    waitDone(lat, to);
    compared++;
    if (to || lat != 13) begin
      mismatched++;
      $display("[TB] FAIL midreset_rerun_latency: got %0d (timeout=%0d) expected 13", lat, to);
    end
    @(negedge clk);
    checkBasicDst("midreset_rerun_dst", 16'h6000);
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_zero_length();
    test_backpressure();
    test_wrap();
    test_back_to_back();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
